// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, oversample factor, divider helper.
// Pure declarations, no logic and no latency.
package uart_pkg;

    localparam int OVS = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_16x_if.sv
// Receiver-side bundle: serial line in, byte plus status strobes out.
// No handshake: strobes are single-cycle pulses the consumer must take when they occur.
interface uart_rx_16x_if;
    logic       rx;
    logic [7:0] data_out;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    modport master (input rx, output data_out, output new_data, output frame_err, output busy);
    modport slave  (output rx, input data_out, input new_data, input frame_err, input busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1, tick is high during the DIV-1 count.
// Clear holds the count at 0 so the tick phase restarts from the clear release.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, 16x oversampled with 2-of-3 mid-bit vote; new_data ~9.6 bit times after start edge.
// No backpressure: new_data / frame_err are one-cycle pulses, data_out holds the last good byte.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_16x_if.master bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);

    state_t     state_q;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] t_q;
    logic [2:0] bit_q;
    logic [1:0] smp_q;
    logic [7:0] shreg_q, data_q;
    logic       new_q, ferr_q, brk_hi_q;
    logic       tick, vote;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .clr_i  (state_q == S_IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // smp_q[1] holds the t=7 sample, smp_q[0] the t=8 sample; rx_s_q is the t=9 sample.
    assign vote = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            bit_q    <= '0;
            smp_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            new_q    <= 1'b0;
            ferr_q   <= 1'b0;
            brk_hi_q <= 1'b0;
        end else begin
            new_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        t_q     <= '0;
                        bit_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    if (tick) begin
                        t_q <= t_q + 4'd1;
                        if (t_q == 4'd7) smp_q[1] <= rx_s_q;
                        if (t_q == 4'd8) smp_q[0] <= rx_s_q;
                        if (state_q == S_START) begin
                            if (t_q == 4'd9 && vote) state_q <= S_IDLE;
                            else if (t_q == 4'd15) state_q <= S_DATA;
                        end else if (state_q == S_DATA) begin
                            if (t_q == 4'd9) shreg_q <= {vote, shreg_q[7:1]};
                            if (t_q == 4'd15) begin
                                if (bit_q == 3'd7) state_q <= S_STOP;
                                else bit_q <= bit_q + 3'd1;
                            end
                        end else if (t_q == 4'd9) begin
                            if (vote) begin
                                data_q  <= shreg_q;
                                new_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                ferr_q   <= 1'b1;
                                brk_hi_q <= 1'b0;
                                state_q  <= S_BREAK;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    // Leave only after the line stays high across one whole tick window.
                    if (!rx_s_q) begin
                        brk_hi_q <= 1'b0;
                    end else if (tick) begin
                        if (brk_hi_q) state_q <= S_IDLE;
                        else brk_hi_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.new_data  = new_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_16x.sv
// Randomised bench for uart_rx_16x: frames are generated from byte values and checked
// against an expected-event queue built from the 8N1 framing rules.
module tb_uart_rx_16x;
    localparam int BIT = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_16x_if bus();

    uart_rx_16x #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         err;
        logic [7:0] dat;
        int         at;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         excl_viol = 0;
    bit         prev_new = 1'b0;
    bit         prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.new_data) got_q.push_back('{1'b0, bus.data_out, cyc});
        if (bus.frame_err) got_q.push_back('{1'b1, bus.data_out, cyc});
        if (bus.new_data && bus.frame_err) excl_viol++;
        if (bus.new_data && prev_new) excl_viol++;
        if (bus.frame_err && prev_err) excl_viol++;
        prev_new = bus.new_data;
        prev_err = bus.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; the model records what a correct receiver must report for it.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int per, input bit glitch);
        logic [9:0] bits;
        int         off;
        bits = {stop, b, 1'b0};
        off  = (per * 7) / 16 + 12;
        for (int i = 0; i < 10; i++) begin
            bus.rx = bits[i];
            if (glitch) begin
                idle(off);
                bus.rx = ~bits[i];
                idle(1);
                bus.rx = bits[i];
                idle(per - off - 1);
            end else begin
                idle(per);
            end
        end
        if (stop) begin
            exp_q.push_back('{1'b0, b, 0});
            last_good = b;
        end else begin
            exp_q.push_back('{1'b1, last_good, 0});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, got_q[i].err, exp_q[i].err);
            check({tag, "_data"}, got_q[i].dat, exp_q[i].dat);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [7:0] b;
        bit         st;
        bus.rx = 1'b1;
        idle(3);
        check("rst_data", bus.data_out, 8'h00);
        check("rst_new", bus.new_data, 1'b0);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        idle(20);

        // Single byte with latency window
        t0 = cyc;
        send_frame(8'h35, 1'b1, BIT, 1'b0);
        idle(100);
        lat = (got_q.size() > 0) ? got_q[0].at - t0 : -1;
        check("t1_latency_ok", (lat >= 1535 && lat <= 1545), 1'b1);
        check("t1_hold", bus.data_out, 8'h35);
        drain("t1");

        // Back-to-back frames, no idle gap
        send_frame(8'h31, 1'b1, BIT, 1'b0);
        send_frame(8'h32, 1'b1, BIT, 1'b0);
        send_frame(8'h33, 1'b1, BIT, 1'b0);
        send_frame(8'h34, 1'b1, BIT, 1'b0);
        idle(200);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 3; i++) check("t2_spacing", got_q[i+1].at - got_q[i].at, 1600);
        end
        drain("t2");

        // False start shorter than half a bit
        bus.rx = 1'b0;
        idle(20);
        check("t3_busy_hi", bus.busy, 1'b1);
        idle(20);
        bus.rx = 1'b1;
        idle(200);
        check("t3_busy_lo", bus.busy, 1'b0);
        check("t3_data", bus.data_out, last_good);
        drain("t3");

        // Bad stop bit, line held low, then recovery
        send_frame(8'hA5, 1'b0, BIT, 1'b0);
        idle(500);
        check("t4_hold_events", got_q.size(), 1);
        bus.rx = 1'b1;
        idle(300);
        check("t4_busy_lo", bus.busy, 1'b0);
        check("t4_data_kept", bus.data_out, 8'h34);
        send_frame(8'h39, 1'b1, BIT, 1'b0);
        idle(100);
        drain("t4");

        // Reset in the middle of a byte
        bus.rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0];
            idle(BIT);
        end
        bus.rx = 1'b1;
        rst = 1'b1;
        idle(1);
        check("t5_rst_data", bus.data_out, 8'h00);
        check("t5_rst_new", bus.new_data, 1'b0);
        check("t5_rst_ferr", bus.frame_err, 1'b0);
        check("t5_rst_busy", bus.busy, 1'b0);
        idle(2);
        rst = 1'b0;
        last_good = 8'h00;
        idle(300);
        check("t5_no_partial", got_q.size(), 0);
        send_frame(8'h30, 1'b1, BIT, 1'b0);
        idle(100);
        drain("t5");

        // Single-cycle glitches with +/-3% baud error
        send_frame(8'h37, 1'b1, 165, 1'b1);
        idle(200);
        send_frame(8'h37, 1'b1, 155, 1'b1);
        idle(200);
        drain("t6");

        // Random bytes, gaps and occasional framing errors
        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            send_frame(b, st, BIT, 1'($urandom_range(0, 1)));
            bus.rx = 1'b1;
            idle(st ? $urandom_range(0, 300) : $urandom_range(100, 300));
        end
        idle(200);
        drain("rnd");

        check("pulse_excl", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
